// File: rtl/updown_checker.sv
// Receive-side checker for a bouncing MIN..MAX..MIN up/down count stream.
// Locks onto the stream direction, flags turnarounds, times the bounce period, reports bad steps.
module updown_checker #(
  parameter int WIDTH   = 3,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] cnt_in_i,
  input  logic             err_clr_i,
  output logic             dir_o,
  output logic             locked_o,
  output logic             peak_o,
  output logic             trough_o,
  output logic             err_o,
  output logic             err_sticky_o,
  output logic [7:0]       period_o,
  output logic             period_valid_o
);

  // state | meaning
  // IDLE  | nothing sampled since reset
  // ACQ   | one reference sample held, direction unknown
  // UP    | locked, stream counting up toward MAX_VAL
  // DOWN  | locked, stream counting down toward MIN_VAL
  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_UP, S_DOWN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             peak_q, peak_d;
  logic             trough_q, trough_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       period_q, period_d;
  logic             pv_q, pv_d;
  logic [7:0]       sc_q, sc_d;
  logic             ts_q, ts_d;

  logic ev_err, ev_peak, ev_trough, ev_adv;

  // Integer view of sample and reference so +/-1 never wraps at the word edges
  int s_v, p_v;
  assign s_v = int'(cnt_in_i);
  assign p_v = int'(prev_q);

  logic in_range, step_up, step_dn, at_max, at_min;
  assign in_range = (s_v >= MIN_VAL) && (s_v <= MAX_VAL);
  assign step_up  = (s_v == p_v + 1);
  assign step_dn  = (s_v == p_v - 1);
  assign at_max   = (p_v == MAX_VAL);
  assign at_min   = (p_v == MIN_VAL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      period_q <= 8'd0;
      pv_q     <= 1'b0;
      sc_q     <= 8'd0;
      ts_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      sc_q     <= sc_d;
      ts_q     <= ts_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ev_err    = 1'b0;
    ev_peak   = 1'b0;
    ev_trough = 1'b0;
    ev_adv    = 1'b0;
    if (in_valid_i) begin
      if (!in_range) begin
        ev_err  = 1'b1;
        state_d = (state_q == S_IDLE) ? S_IDLE : S_ACQ;
      end else begin
        unique case (state_q)
          S_IDLE: state_d = S_ACQ;
          S_ACQ: begin
            if (step_up)      state_d = S_UP;
            else if (step_dn) state_d = S_DOWN;
            else              ev_err  = 1'b1;
          end
          S_UP: begin
            if (!at_max && step_up) begin
              ev_adv = 1'b1;
            end else if (at_max && step_dn) begin
              state_d = S_DOWN;
              ev_peak = 1'b1;
              ev_adv  = 1'b1;
            end else begin
              ev_err  = 1'b1;
              state_d = S_ACQ;
            end
          end
          S_DOWN: begin
            if (!at_min && step_dn) begin
              ev_adv = 1'b1;
            end else if (at_min && step_up) begin
              state_d   = S_UP;
              ev_trough = 1'b1;
              ev_adv    = 1'b1;
            end else begin
              ev_err  = 1'b1;
              state_d = S_ACQ;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    prev_d   = prev_q;
    dir_d    = dir_q;
    sc_d     = sc_q;
    ts_d     = ts_q;
    period_d = period_q;
    pv_d     = 1'b0;
    sticky_d = sticky_q;
    locked_d = (state_d == S_UP) || (state_d == S_DOWN);
    peak_d   = ev_peak;
    trough_d = ev_trough;
    err_d    = ev_err;
    if (err_clr_i) sticky_d = 1'b0;
    if (in_valid_i) begin
      prev_d = cnt_in_i;
      if (ev_err) begin
        sticky_d = 1'b1;
        sc_d     = 8'd0;
        ts_d     = 1'b0;
      end else begin
        if (state_d == S_UP)        dir_d = 1'b0;
        else if (state_d == S_DOWN) dir_d = 1'b1;
        if (ev_trough) begin
          if (ts_q) begin
            period_d = (sc_q == 8'hFF) ? 8'hFF : sc_q + 8'd1;
            pv_d     = 1'b1;
          end
          sc_d = 8'd0;
          ts_d = 1'b1;
        end else if (ev_adv) begin
          sc_d = (sc_q == 8'hFF) ? 8'hFF : sc_q + 8'd1;
        end
      end
    end
  end

  assign dir_o          = dir_q;
  assign locked_o       = locked_q;
  assign peak_o         = peak_q;
  assign trough_o       = trough_q;
  assign err_o          = err_q;
  assign err_sticky_o   = sticky_q;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;

endmodule

// File: tb/tb_updown_checker.sv
// Self-checking bench for updown_checker: directed scenarios plus random bounce
// stream with stalls and glitches, compared every cycle against a behavioural model.
module tb_updown_checker;
  localparam int W  = 3;
  localparam int MN = 0;
  localparam int MX = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] cnt;
  logic         err_clr;
  logic         dir, locked, peak, trough, err, err_sticky, period_valid;
  logic [7:0]   period;

  updown_checker #(.WIDTH(W), .MIN_VAL(MN), .MAX_VAL(MX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .cnt_in_i(cnt),
    .err_clr_i(err_clr), .dir_o(dir), .locked_o(locked), .peak_o(peak),
    .trough_o(trough), .err_o(err), .err_sticky_o(err_sticky),
    .period_o(period), .period_valid_o(period_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: "started" = a reference sample exists, "locked" = direction known.
  // When locked the only legal sample is the bounce successor of prev.
  bit m_started, m_locked, m_dir, m_sticky;
  int m_prev, m_n, m_last_trough, m_period;
  bit e_peak, e_trough, e_err, e_pv;

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_dir = 0; m_sticky = 0;
    m_prev = 0; m_n = 0; m_last_trough = -1; m_period = 0;
    e_peak = 0; e_trough = 0; e_err = 0; e_pv = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit clr);
    bit bad;
    int nxt;
    bad = 0;
    e_peak = 0; e_trough = 0; e_err = 0; e_pv = 0;
    if (v) begin
      if (s < MN || s > MX) begin
        bad = 1;
      end else if (!m_started) begin
        m_started = 1;
      end else if (!m_locked) begin
        if (s == m_prev + 1)      begin m_locked = 1; m_dir = 0; end
        else if (s == m_prev - 1) begin m_locked = 1; m_dir = 1; end
        else bad = 1;
      end else begin
        if (m_dir == 0) nxt = (m_prev < MX) ? m_prev + 1 : m_prev - 1;
        else            nxt = (m_prev > MN) ? m_prev - 1 : m_prev + 1;
        if (s == nxt) begin
          m_n++;
          if (m_dir == 0 && m_prev == MX) begin e_peak = 1; m_dir = 1; end
          else if (m_dir == 1 && m_prev == MN) begin
            e_trough = 1; m_dir = 0;
            if (m_last_trough >= 0) begin
              m_period = (m_n - m_last_trough > 255) ? 255 : m_n - m_last_trough;
              e_pv = 1;
            end
            m_last_trough = m_n;
          end
        end else begin
          bad = 1;
        end
      end
      if (bad) begin
        e_err = 1;
        m_locked = 0;
        m_last_trough = -1;
      end
      m_prev = s;
    end
    if (bad) m_sticky = 1;
    else if (clr) m_sticky = 0;
  endtask

  task automatic compare_all();
    chk("dir", int'(dir), int'(m_dir));
    chk("locked", int'(locked), int'(m_locked));
    chk("peak", int'(peak), int'(e_peak));
    chk("trough", int'(trough), int'(e_trough));
    chk("err", int'(err), int'(e_err));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("period", int'(period), m_period);
    chk("period_valid", int'(period_valid), int'(e_pv));
  endtask

  int n_peak, n_trough, n_pv, first_pv_idx;

  task automatic step(input bit v, input int s, input bit clr);
    int sv;
    sv = s;
    in_valid = v;
    cnt      = sv[W-1:0];
    err_clr  = clr;
    @(posedge clk);
    model_step(v, s, clr);
    #1;
    compare_all();
    if (peak) n_peak++;
    if (trough) n_trough++;
    if (period_valid) n_pv++;
  endtask

  int g_val, g_dir;
  task automatic gen_adv();
    if (g_dir == 0) begin
      if (g_val == MX) begin g_dir = 1; g_val--; end else g_val++;
    end else begin
      if (g_val == MN) begin g_dir = 0; g_val++; end else g_val--;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; cnt = '0; err_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("rst_locked_lit", int'(locked), 0);
    chk("rst_period_lit", int'(period), 0);
    chk("rst_sticky_lit", int'(err_sticky), 0);
    @(negedge clk);
    rst_n = 1;

    // Nominal stream from 0 with a 10-cycle stall mid-sequence
    n_peak = 0; n_trough = 0; n_pv = 0;
    g_val = 0; g_dir = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, g_val, 0);
      if (i == 0) chk("lock_after_1_lit", int'(locked), 0);
      if (i == 1) chk("lock_after_2_lit", int'(locked), 1);
      if (i == 20) begin
        for (int k = 0; k < 10; k++) begin
          step(0, 5, 0);
          chk("stall_pulse_lit", int'(peak | trough | err | period_valid), 0);
        end
      end
      gen_adv();
    end
    chk("nom_peaks_lit", n_peak, 2);
    chk("nom_troughs_lit", n_trough, 2);
    chk("nom_pv_count_lit", n_pv, 1);
    chk("nom_period_lit", int'(period), 14);
    chk("nom_no_err_lit", int'(err_sticky), 0);

    // Off-extreme reversal while UP: 2,3,4 then 3
    step(1, 2, 0); step(1, 3, 0); step(1, 4, 0);
    step(1, 3, 0);
    chk("rev_err_lit", int'(err), 1);
    chk("rev_sticky_lit", int'(err_sticky), 1);
    chk("rev_unlock_lit", int'(locked), 0);
    step(1, 2, 0);
    chk("relock_lit", int'(locked), 1);
    chk("relock_dir_lit", int'(dir), 1);
    chk("relock_noerr_lit", int'(err), 0);

    // Clear colliding with a new error: set wins; clear alone then clears
    step(1, 2, 1);
    chk("clr_collide_err_lit", int'(err), 1);
    chk("clr_collide_sticky_lit", int'(err_sticky), 1);
    step(0, 0, 1);
    chk("clr_alone_lit", int'(err_sticky), 0);

    // Walk to DOWN at 4, then async reset mid-cycle
    step(1, 3, 0); step(1, 4, 0); step(1, 5, 0); step(1, 6, 0); step(1, 7, 0);
    step(1, 6, 0); step(1, 5, 0); step(1, 4, 0);
    chk("pre_rst_down_lit", int'(dir), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    compare_all();
    chk("async_rst_locked_lit", int'(locked), 0);
    chk("async_rst_dir_lit", int'(dir), 0);
    @(negedge clk);
    rst_n = 1;
    step(1, 4, 0);
    chk("post_rst_first_noerr_lit", int'(err), 0);
    step(1, 3, 0);
    chk("post_rst_locked_lit", int'(locked), 1);
    chk("post_rst_dir_lit", int'(dir), 1);
    chk("post_rst_noerr_lit", int'(err), 0);

    // Mid-stream start 5,4,3...: period only after two troughs
    do_reset();
    g_val = 5; g_dir = 1; n_pv = 0; first_pv_idx = -1;
    for (int i = 0; i < 24; i++) begin
      step(1, g_val, 0);
      if (i == 1) chk("mid_dir_lit", int'(dir), 1);
      if (period_valid && first_pv_idx < 0) first_pv_idx = i;
      gen_adv();
    end
    chk("mid_first_pv_lit", first_pv_idx, 20);
    chk("mid_period_lit", int'(period), 14);
    chk("mid_no_err_lit", int'(err_sticky), 0);

    // Random bounce stream with stalls, glitches and clears
    for (int i = 0; i < 3000; i++) begin
      bit v, clr, gl;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      gl  = ($urandom_range(0, 19) == 0);
      if (gl) step(v, $urandom_range(MN, MX), clr);
      else    step(v, g_val, clr);
      if (v && !gl) gen_adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/updown_checker.md
Name: updown_checker

Overview:
- Receive-side monitor for the bouncing up/down count stream (MIN→MAX→MIN→…, turning only at the extremes).
- Samples a count word on each valid cycle, locks onto the stream direction, and flags peaks and troughs.
- Measures the full bounce period and reports any illegal step.
- Sits downstream of the up/down counter as its checker/decoder, in both the datapath and the verification harness.

Parameters:
- WIDTH, 3, count word width.
- MIN_VAL, 0, lower turnaround value; must be < MAX_VAL.
- MAX_VAL, 7, upper turnaround value; must be ≤ 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in_valid  input  1  cnt_in is sampled this cycle.
- cnt_in  input  WIDTH  incoming count value.
- err_clr  input  1  synchronous clear of err_sticky.
- dir  output  1  current tracked direction: 0 = up, 1 = down.
- locked  output  1  high in states UP and DOWN.
- peak  output  1  one-cycle pulse on an accepted down-turn at MAX_VAL.
- trough  output  1  one-cycle pulse on an accepted up-turn at MIN_VAL.
- err  output  1  one-cycle pulse on an illegal sample.
- err_sticky  output  1  latched error.
- period  output  8  last measured bounce period in samples, saturating at 255.
- period_valid  output  1  one-cycle pulse when period updates.

Behaviour:
- Reset (rst=0, async): state=IDLE, prev=0, dir=0, locked=0, all pulses 0, err_sticky=0, period=0, sample counter sc=0, trough_seen=0.
- All outputs are registered. Response appears the cycle after the valid sample edge (latency 1).
- in_valid=0: state, prev, sc and flags hold; pulses are 0 that cycle.
- Any sample s outside [MIN_VAL, MAX_VAL] is illegal in every state.
- The accepted sample always updates prev<=s, including error samples (resync).
- FSM on each valid sample s, with p = prev:
  - IDLE: store s → ACQ. No error possible except out-of-range, which stays in IDLE.
  - ACQ:
    - s==p+1 → UP, dir=0.
    - s==p-1 → DOWN, dir=1.
    - p==MAX_VAL and s==MAX_VAL-1 → DOWN.
    - p==MIN_VAL and s==MIN_VAL+1 → UP.
    - Anything else → err, stay ACQ.
    - No peak/trough pulses from ACQ.
  - UP:
    - p<MAX_VAL and s==p+1 → stay UP.
    - p==MAX_VAL and s==MAX_VAL-1 → DOWN, dir=1, peak=1.
    - Else → err, go ACQ.
  - DOWN:
    - p>MIN_VAL and s==p-1 → stay DOWN.
    - p==MIN_VAL and s==MIN_VAL+1 → UP, dir=0, trough=1.
    - Else → err, go ACQ.
- Repeated value (s==p) is illegal in UP, DOWN and ACQ. Reversal away from an extreme is illegal.
- Error handling:
  - err pulses and err_sticky<=1.
  - sc<=0, trough_seen<=0.
  - period holds its last value.
- err_clr clears err_sticky the next edge. If err_clr and a new error occur in the same cycle, the set wins.
- Period measurement (accepted legal samples in UP/DOWN only):
  - On a trough sample: if trough_seen, period<=min(sc+1, 255) and period_valid=1. Then sc<=0 and trough_seen<=1.
  - Otherwise sc<=sc+1, saturating at 255.
  - Nominal period = 2*(MAX_VAL-MIN_VAL) = 14 for defaults.
- Async reset mid-stream returns to IDLE immediately. The first post-reset sample never errors unless out of range.

Test Plan:
- Reset, then feed the counter stream 0,1,2,…,7,6,…,0,1,…:
  - locked rises after sample 2.
  - peak pulses on the 6 following 7.
  - trough pulses on the 1 following 0.
  - Second trough gives period=14 with period_valid=1.
  - err never fires.
- Start mid-stream at 5,4,3: ACQ→DOWN with dir=1, no err; first period_valid only after two troughs.
- Inject 3,4,3 while UP (reversal off-extreme): err pulse, err_sticky=1, state ACQ, locked=0. Stream 3,2 relocks DOWN.
- Stall with in_valid=0 for 10 cycles mid-sequence: outputs hold, no pulses, period still 14 at the next trough.
- Assert err_clr in the same cycle as an error sample: err_sticky stays 1. err_clr alone next cycle: err_sticky=0.
- Assert rst low while DOWN at cnt 4: all outputs go to reset values asynchronously. After release, stream 4,3 → DOWN with no err.
